text_scan_fetch: RTL

//  Reader side of the display mode decode: consumes the latched mode outputs (row_width,
//  row_height, pixel_divider) and walks text-mode video memory once per frame. Issues one
//  req/ack word read per character cell per scanline; buffers returned words in a 2-entry

---
 rtl/text_scan_fetch.sv | 111 +++++++++++
 1 files changed

// File: rtl/text_scan_fetch.sv
// text_scan_fetch: walks text-mode video memory once per frame and buffers character words with their glyph row
module text_scan_fetch #(
  parameter int ADDRESS_WIDTH = 17,
  parameter int DATA_WIDTH    = 16
) (
  input  logic                     cpu_clk,
  input  logic                     reset_n,
  input  logic                     frame_start,
  input  logic                     line_start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [7:0]               row_width,
  input  logic [7:0]               row_height,
  input  logic [2:0]               pixel_divider,
  output logic                     fetch_req,
  output logic [ADDRESS_WIDTH-1:0] fetch_addr,
  input  logic                     fetch_ack,
  input  logic [DATA_WIDTH-1:0]    fetch_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [2:0]               out_glyph_row,
  output logic                     underrun,
  output logic                     frame_done
);
  typedef enum logic [1:0] {IDLE, LINE_WAIT, FETCH} state_t;
  state_t state;
  logic [7:0] width_q, height_q, col, char_row;
  logic [2:0] div_q, sub_line, glyph_row, sub_next, glyph_next;
  logic [ADDRESS_WIDTH-1:0] row_base;
  logic [DATA_WIDTH+2:0] mem [2];
  logic rd_ptr, wr_ptr;
  logic [1:0] count;
  logic pop, take, last_cell, last_sub, char_inc, frame_end, line_end, free;
  assign fetch_addr = row_base + ADDRESS_WIDTH'(col);
  assign out_valid = count != 2'd0;
  assign out_data = mem[rd_ptr][DATA_WIDTH-1:0];
  assign out_glyph_row = mem[rd_ptr][DATA_WIDTH+2:DATA_WIDTH];
  // Scan position bookkeeping: when a scanline ends (normally or cut short by line_start) and what comes next
  always_comb begin
    pop = out_valid && out_ready;
    take = state == FETCH && fetch_req && fetch_ack && !line_start;
    last_cell = col == width_q - 8'd1;
    last_sub = sub_line == div_q;
    char_inc = last_sub && glyph_row == 3'd7;
    frame_end = char_inc && char_row == height_q - 8'd1;
    line_end = state == FETCH && (line_start || (take && last_cell));
    free = !count[1] || pop;
    sub_next = last_sub ? 3'd0 : sub_line + 3'd1;
    glyph_next = last_sub ? glyph_row + 3'd1 : glyph_row;
  end
  // Frame FSM, request handshake, scan counters and the 2-entry word FIFO
  always_ff @(posedge cpu_clk) begin
    if (!reset_n) begin
      state <= IDLE;
      width_q <= '0;
      height_q <= '0;
      div_q <= '0;
      col <= '0;
      char_row <= '0;
      sub_line <= '0;
      glyph_row <= '0;
      row_base <= '0;
      fetch_req <= 1'b0;
      underrun <= 1'b0;
      frame_done <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count <= '0;
    end else if (frame_start) begin
      state <= LINE_WAIT;
      width_q <= row_width;
      height_q <= row_height;
      div_q <= pixel_divider;
      col <= '0;
      char_row <= '0;
      sub_line <= '0;
      glyph_row <= '0;
      row_base <= base_addr;
      fetch_req <= 1'b0;
      underrun <= 1'b0;
      frame_done <= 1'b0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count <= '0;
    end else begin
      underrun <= state == FETCH && line_start;
      frame_done <= line_end && frame_end;
      fetch_req <= state == FETCH && !line_end && !(fetch_req && fetch_ack) && (fetch_req || free);
      state <= (state == LINE_WAIT && line_start) ? FETCH :
               line_end ? (frame_end ? IDLE : line_start ? FETCH : LINE_WAIT) : state;
      count <= count + {1'b0, take} - {1'b0, pop};
      if (take) begin
        mem[wr_ptr] <= {glyph_row, fetch_data};
        wr_ptr <= ~wr_ptr;
        col <= col + 8'd1;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      if (line_end) begin
        col <= '0;
        sub_line <= sub_next;
        glyph_row <= glyph_next;
        if (char_inc) begin
          char_row <= char_row + 8'd1;
          row_base <= row_base + ADDRESS_WIDTH'(width_q);
        end
      end
    end
  end
endmodule
